// File: rtl/regfile_8x16.sv
// regfile_8x16: DEPTH x WIDTH register file, one write port, two registered read ports.
module regfile_8x16 #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic [DEPTH-1:0] we_onehot
);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] rd_a, rd_b;
  always_comb begin
    we_onehot = '0;
    for (int i = 0; i < DEPTH; i++)
      we_onehot[i] = we && waddr == AW'(i) && !(ZERO_R0 != 0 && i == 0);
  end
  // Unmatched addresses (out of range, or R0 when hardwired) fall through to 0.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_a == AW'(i) && !(ZERO_R0 != 0 && i == 0))
        rd_a = (BYPASS != 0 && we_onehot[i]) ? wdata : regs[i];
      if (raddr_b == AW'(i) && !(ZERO_R0 != 0 && i == 0))
        rd_b = (BYPASS != 0 && we_onehot[i]) ? wdata : regs[i];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (we_onehot[i]) regs[i] <= wdata;
      if (re_a) rdata_a <= rd_a;
      if (re_b) rdata_b <= rd_b;
    end
  end
endmodule

// File: tb/tb_regfile_8x16.sv
// tb_regfile_8x16: directed and random checks of regfile_8x16 against an array model.
module tb_regfile_8x16;
  logic        clk = 0;
  logic        rst = 1;
  logic        we = 0, re_a = 0, re_b = 0;
  logic [2:0]  waddr = 0, raddr_a = 0, raddr_b = 0;
  logic [15:0] wdata = 0;
  logic [15:0] rdata_a, rdata_b;
  logic [7:0]  we_onehot;
  logic [15:0] mem [8];
  logic [15:0] exp_a = 0, exp_b = 0;
  int checks = 0, errors = 0;

  regfile_8x16 dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .we_onehot(we_onehot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value a read of address a sees on an edge carrying write (w, wa, wd).
  function automatic logic [15:0] mread(input logic [2:0] a, input logic w,
                                        input logic [2:0] wa, input logic [15:0] wd);
    if (a == 0) return 16'h0000;
    if (w && wa == a) return wd;
    return mem[a];
  endfunction

  task automatic step(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                      input logic ea, input logic [2:0] ra,
                      input logic eb, input logic [2:0] rb);
    we = w; waddr = wa; wdata = wd; re_a = ea; raddr_a = ra; re_b = eb; raddr_b = rb;
    #1 check("we_onehot", {8'h00, we_onehot}, {8'h00, (w && wa != 0) ? 8'(1) << wa : 8'h00});
    @(posedge clk);
    if (ea) exp_a = mread(ra, w, wa, wd);
    if (eb) exp_b = mread(rb, w, wa, wd);
    if (w && wa != 0) mem[wa] = wd;
    #1;
    check("rdata_a", rdata_a, exp_a);
    check("rdata_b", rdata_b, exp_b);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    #1;
    check("async_reset_a", rdata_a, 16'h0000);
    check("async_reset_b", rdata_b, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 3'(i), 1, 3'(7 - i));
    // Write sweep, including an attempt on hardwired R0.
    step(1, 0, 16'hDEAD, 0, 0, 0, 0);
    for (int i = 1; i < 8; i++) step(1, 3'(i), 16'hA000 + 16'(i), 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 3'(i), 1, 3'(7 - i));
      check("sweep_a_const", rdata_a, i == 0 ? 16'h0000 : 16'hA000 + 16'(i));
    end
    // Bypass
    step(1, 3, 16'h1111, 0, 0, 0, 0);
    step(1, 3, 16'h2222, 1, 3, 1, 3);
    check("bypass_const", rdata_a, 16'h2222);
    // Read hold
    step(0, 0, 0, 1, 4, 0, 0);
    step(1, 4, 16'hBEEF, 0, 4, 0, 0);
    check("hold_const", rdata_a, 16'hA004);
    step(0, 0, 0, 1, 4, 0, 0);
    check("hold_release", rdata_a, 16'hBEEF);
    // Decode boundaries
    we = 1; waddr = 5; #1 check("onehot_5", {8'h00, we_onehot}, 16'h0020);
    we = 0; #1 check("onehot_we0", {8'h00, we_onehot}, 16'h0000);
    we = 1; waddr = 0; #1 check("onehot_r0", {8'h00, we_onehot}, 16'h0000);
    we = 0;
    for (int n = 0; n < 300; n++)
      step(1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom), 3'($urandom),
           1'($urandom), 3'($urandom));
    // Reset mid-operation
    step(1, 2, 16'h5A5A, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 1, 2);
    check("dual_read", rdata_b, 16'h5A5A);
    #2 rst = 1;
    #1;
    check("mid_reset_a", rdata_a, 16'h0000);
    check("mid_reset_b", rdata_b, 16'h0000);
    we = 1; waddr = 2; wdata = 16'hFFFF; re_a = 1; raddr_a = 2;
    #1 check("onehot_in_reset", {8'h00, we_onehot}, 16'h0004);
    @(posedge clk);
    #1 check("reset_edge_read", rdata_a, 16'h0000);
    rst = 0; we = 0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    exp_a = 0; exp_b = 0;
    step(0, 0, 0, 1, 2, 1, 5);
    check("reg2_after_reset", rdata_a, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_8x16.md
Name: regfile_8x16

Overview:
- Register file that consumes the routed write-enable produced by the 1-bit demultiplexer stage. The demux selects the write destination; this block holds the processor's general-purpose registers.
- Provides one write port and two registered read ports, A and B, for the 16-bit datapath. Same-cycle write-to-read bypass is optional.
- Sits between the writeback routing logic and the ALU operand inputs.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 8, number of registers.
- AW, 3, address width; DEPTH must be <= 2**AW.
- ZERO_R0, 1, when 1: register 0 reads as 0 and ignores writes.
- BYPASS, 1, when 1: a read that coincides with a write to the same address returns the new data.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write enable from the demux stage.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- re_a  in  1  read enable, port A.
- raddr_a  in  AW  read address, port A.
- re_b  in  1  read enable, port B.
- raddr_b  in  AW  read address, port B.
- rdata_a  out  WIDTH  registered read data, port A.
- rdata_b  out  WIDTH  registered read data, port B.
- we_onehot  out  DEPTH  combinational decoded write strobe, for debug and cascade.

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high.
- Reset:
  - Asserting rst immediately clears all DEPTH registers, rdata_a and rdata_b to 0. No clock edge is needed.
  - Deassertion takes effect on the next rising edge; the first write is accepted on the first edge with rst low.
  - Reset asserted mid-operation discards any in-flight write or read on that edge.
- Write:
  - On a rising edge with we=1 and waddr < DEPTH, reg[waddr] <= wdata.
  - Ignored when ZERO_R0=1 and waddr=0.
  - Ignored when waddr >= DEPTH. No error flag is raised.
- Read:
  - Latency is 1 cycle. On a rising edge with re_x=1, rdata_x <= value of reg[raddr_x].
  - With re_x=0, rdata_x holds its previous value.
  - raddr_x >= DEPTH returns 0.
  - ZERO_R0=1 with raddr_x=0 returns 0.
- Bypass (same edge: we=1, re_x=1, raddr_x==waddr, write not ignored):
  - BYPASS=1: rdata_x <= wdata.
  - BYPASS=0: rdata_x <= the old register contents.
  - An ignored write (R0 or out of range) is never bypassed.
- Dual read: both ports may read the same address on the same edge, and both receive identical data.
- we_onehot:
  - Equals (1 << waddr) when we=1 and waddr < DEPTH, else all zeros.
  - Bit 0 is forced to 0 when ZERO_R0=1.
  - Purely combinational, with no dependency on rst.
- Width rules:
  - All data is WIDTH bits with no sign handling.
  - Addresses are compared as unsigned AW-bit values.
- No internal FSM beyond register state. Throughput is one write and two reads per cycle, with no stalls.

Test Plan:
- Reset: drive rst=1 with clk running, then release. All rdata = 16'h0000. Reading each address 0-7 returns 0; reset clears outputs asynchronously, before the next edge.
- Write/read sweep: write reg[i] = 16'hA000+i for i=1..7, then read via A and B with raddr_a=i, raddr_b=7-i. Each port returns its value exactly 1 cycle after the read edge. Address 0 returns 16'h0000, since the write of R0 is ignored.
- Bypass:
  - With reg[3]=16'h1111, on one edge set we=1, waddr=3, wdata=16'h2222, re_a=1, raddr_a=3. Expect rdata_a=16'h2222.
  - With BYPASS=0 the same stimulus gives 16'h1111; a read on the next edge gives 16'h2222.
- Read hold: set re_a=0 while writing reg[raddr_a]=16'hBEEF. rdata_a stays at its old value until re_a=1, then shows 16'hBEEF one cycle later.
- Decode and boundary: for waddr=5 with we=1, we_onehot = 8'b0010_0000. With we=0, we_onehot = 8'h00. With waddr=0, we_onehot = 8'h00.
- Reset mid-operation: after writing reg[2]=16'h5A5A, assert rst between edges. rdata and reg[2] read 0 after release, and a write issued on the reset edge has no effect.
